// File: rtl/pc_sequencer.sv
// Program counter and return-address stack: next-PC select, call/return stack, sticky fault flags.
// Optional build macro PC_SEQ_STACK_TRAP_EN: stack faults redirect the PC to TRAP_VECTOR.
module pc_sequencer #(
   parameter int                     PC_WIDTH     = 12,
   parameter int                     OFFSET_WIDTH = 8,
   parameter int                     STACK_DEPTH  = 8,
   parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = 12'h000,
   parameter logic [PC_WIDTH-1:0]    TRAP_VECTOR  = 12'hFF0,
   localparam int                    DW           = $clog2(STACK_DEPTH)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable_pc,
   input  logic [1:0]                select_address,
   input  logic [PC_WIDTH-1:0]       jump_address,
   input  logic [OFFSET_WIDTH-1:0]   branch_offset,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      ret,
   output logic [PC_WIDTH-1:0]       pc,
   output logic [DW:0]               stack_depth,
   output logic                      stack_full,
   output logic                      stack_empty,
   output logic                      stack_overflow,
   output logic                      stack_underflow,
   output logic                      protocol_error
);

`ifdef PC_SEQ_STACK_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam logic [DW:0]          FULL_D = (DW+1)'(STACK_DEPTH);
   localparam logic [DW:0]          ONE_D  = (DW+1)'(1);
   localparam logic [PC_WIDTH-1:0]  ONE_PC = PC_WIDTH'(1);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [DW:0]         depth_q, depth_d;
   logic                ovf_q, ovf_d;
   logic                und_q, und_d;
   logic                perr_q, perr_d;
   logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

   logic                full, empty;
   logic                ovf_ev, und_ev, perr_ev, fault;
   logic                wr_en, do_pop;
   logic [DW-1:0]       wr_idx, rd_idx;
   logic [PC_WIDTH-1:0] pc_inc, pc_br, top;

   assign full   = (depth_q == FULL_D);
   assign empty  = (depth_q == '0);
   assign wr_idx = depth_q[DW-1:0];
   assign rd_idx = DW'(depth_q - ONE_D);
   assign top    = stack_q[rd_idx];
   assign pc_inc = pc_q + ONE_PC;
   assign pc_br  = pc_inc + {{(PC_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}}, branch_offset};

   // Simultaneous push+pop cancels both stack ops; ret is judged independently.
   assign perr_ev = enable_pc & push & pop;
   assign ovf_ev  = enable_pc & push & ~pop & full;
   assign und_ev  = enable_pc & ((ret & empty) | (pop & ~push & empty));
   assign fault   = TRAP_EN & (ovf_ev | und_ev);
   assign wr_en   = enable_pc & push & ~pop & ~full & ~fault;
   assign do_pop  = enable_pc & pop & ~push & ~empty & ~fault;

   always_comb begin
      pc_d = pc_q;
      if (enable_pc) begin
         if (ret && !empty)
            pc_d = top;
         else if (ret)
            pc_d = pc_inc;
         else begin
            case (select_address)
               2'b10:   pc_d = jump_address;
               2'b01:   pc_d = pc_br;
               default: pc_d = pc_inc;
            endcase
         end
         if (fault)
            pc_d = TRAP_VECTOR;
      end
   end

   always_comb begin
      depth_d = depth_q;
      if (wr_en)
         depth_d = depth_q + ONE_D;
      else if (do_pop)
         depth_d = depth_q - ONE_D;
      ovf_d  = ovf_q | ovf_ev;
      und_d  = und_q | und_ev;
      perr_d = perr_q | perr_ev;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_VECTOR;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         und_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         und_q   <= und_d;
         perr_q  <= perr_d;
      end
   end

   // Stack contents are don't-care after reset, so no reset on the storage.
   always_ff @(posedge clock) begin
      if (wr_en)
         stack_q[wr_idx] <= pc_inc;
   end

   assign pc              = pc_q;
   assign stack_depth     = depth_q;
   assign stack_full      = full;
   assign stack_empty     = empty;
   assign stack_overflow  = ovf_q;
   assign stack_underflow = und_q;
   assign protocol_error  = perr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; follows PC_SEQ_STACK_TRAP_EN for trap expectations.
module tb_pc_sequencer;

`ifdef PC_SEQ_STACK_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        enable_pc;
   logic [1:0]  select_address;
   logic [11:0] jump_address;
   logic [7:0]  branch_offset;
   logic        push, pop, ret;
   logic [11:0] pc;
   logic [3:0]  stack_depth;
   logic        stack_full, stack_empty;
   logic        stack_overflow, stack_underflow, protocol_error;

   int passed = 0;
   int total  = 0;

   pc_sequencer dut (
      .clock           (clock),
      .reset           (reset),
      .enable_pc       (enable_pc),
      .select_address  (select_address),
      .jump_address    (jump_address),
      .branch_offset   (branch_offset),
      .push            (push),
      .pop             (pop),
      .ret             (ret),
      .pc              (pc),
      .stack_depth     (stack_depth),
      .stack_full      (stack_full),
      .stack_empty     (stack_empty),
      .stack_overflow  (stack_overflow),
      .stack_underflow (stack_underflow),
      .protocol_error  (protocol_error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic en, input logic [1:0] sel, input logic [11:0] ja,
                        input logic [7:0] off, input logic pu, input logic po, input logic rt);
      enable_pc      = en;
      select_address = sel;
      jump_address   = ja;
      branch_offset  = off;
      push           = pu;
      pop            = po;
      ret            = rt;
   endtask

   task automatic chk_flags(input string tag, input logic ovf, input logic und, input logic perr);
      chk({tag, "_ovf"},  {15'd0, stack_overflow},  {15'd0, ovf});
      chk({tag, "_und"},  {15'd0, stack_underflow}, {15'd0, und});
      chk({tag, "_perr"}, {15'd0, protocol_error},  {15'd0, perr});
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
      #12;
      chk("rst_pc", {4'd0, pc}, 16'h000);
      chk("rst_depth", {12'd0, stack_depth}, 16'd0);
      chk("rst_empty", {15'd0, stack_empty}, 16'd1);
      chk("rst_full", {15'd0, stack_full}, 16'd0);
      chk_flags("rst", 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // sequential and wrap
      drive(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
      step(); chk("seq1", {4'd0, pc}, 16'h001);
      step(); chk("seq2", {4'd0, pc}, 16'h002);
      step(); chk("seq3", {4'd0, pc}, 16'h003);
      drive(1'b1, 2'b10, 12'hFFF, 8'h00, 1'b0, 1'b0, 1'b0);
      step(); chk("jmp_fff", {4'd0, pc}, 16'hFFF);
      drive(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
      step(); chk("wrap", {4'd0, pc}, 16'h000);

      // branch, jump, hold
      drive(1'b1, 2'b10, 12'h010, 8'h00, 1'b0, 1'b0, 1'b0);
      step(); chk("jmp_010", {4'd0, pc}, 16'h010);
      drive(1'b1, 2'b01, 12'h000, 8'hFC, 1'b0, 1'b0, 1'b0);
      step(); chk("br_neg", {4'd0, pc}, 16'h00D);
      drive(1'b1, 2'b10, 12'h3A5, 8'h00, 1'b0, 1'b0, 1'b0);
      step(); chk("jmp_3a5", {4'd0, pc}, 16'h3A5);
      drive(1'b0, 2'b10, 12'h111, 8'h00, 1'b1, 1'b0, 1'b1);
      step(); step();
      chk("hold_pc", {4'd0, pc}, 16'h3A5);
      chk("hold_depth", {12'd0, stack_depth}, 16'd0);
      drive(1'b1, 2'b10, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
      step(); chk("jmp_000", {4'd0, pc}, 16'h000);
      drive(1'b1, 2'b01, 12'h000, 8'h80, 1'b0, 1'b0, 1'b0);
      step(); chk("br_wrap_neg", {4'd0, pc}, 16'hF81);
      drive(1'b1, 2'b01, 12'h000, 8'h05, 1'b0, 1'b0, 1'b0);
      step(); chk("br_pos", {4'd0, pc}, 16'hF87);
      drive(1'b1, 2'b11, 12'h123, 8'h05, 1'b0, 1'b0, 1'b0);
      step(); chk("sel_11", {4'd0, pc}, 16'hF88);

      // call / return
      drive(1'b1, 2'b10, 12'h020, 8'h00, 1'b0, 1'b0, 1'b0);
      step(); chk("jmp_020", {4'd0, pc}, 16'h020);
      drive(1'b1, 2'b10, 12'h100, 8'h00, 1'b1, 1'b0, 1'b0);
      step();
      chk("call_pc", {4'd0, pc}, 16'h100);
      chk("call_depth", {12'd0, stack_depth}, 16'd1);
      drive(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1);
      step();
      chk("ret_pc", {4'd0, pc}, 16'h021);
      chk("ret_depth", {12'd0, stack_depth}, 16'd0);
      chk_flags("ret", 1'b0, 1'b0, 1'b0);

      // peek-return, then separate pop
      drive(1'b1, 2'b10, 12'h200, 8'h00, 1'b1, 1'b0, 1'b0);
      step(); chk("call2_depth", {12'd0, stack_depth}, 16'd1);
      drive(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b1);
      step();
      chk("peek_pc", {4'd0, pc}, 16'h022);
      chk("peek_depth", {12'd0, stack_depth}, 16'd1);
      drive(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
      chk("pop_pc", {4'd0, pc}, 16'h023);
      chk("pop_depth", {12'd0, stack_depth}, 16'd0);

      // overflow: entries 0x024, 0x401..0x407
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'b10, 12'h400 + 12'(i), 8'h00, 1'b1, 1'b0, 1'b0);
         step();
         chk("fill_depth", {12'd0, stack_depth}, 16'(i + 1));
      end
      chk("full", {15'd0, stack_full}, 16'd1);
      drive(1'b1, 2'b10, 12'h500, 8'h00, 1'b1, 1'b0, 1'b0);
      step();
      chk("ovf_pc", {4'd0, pc}, TRAP ? 16'hFF0 : 16'h500);
      chk("ovf_depth", {12'd0, stack_depth}, 16'd8);
      chk_flags("ovf", 1'b1, 1'b0, 1'b0);
      drive(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1);
      step();
      chk("ret_top_pc", {4'd0, pc}, 16'h407);
      chk("ret_top_depth", {12'd0, stack_depth}, 16'd7);
      chk("not_full", {15'd0, stack_full}, 16'd0);

      // reset clears sticky flags
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      chk_flags("rst2", 1'b0, 1'b0, 1'b0);

      // underflow
      drive(1'b1, 2'b10, 12'h040, 8'h00, 1'b0, 1'b0, 1'b0);
      step(); chk("jmp_040", {4'd0, pc}, 16'h040);
      drive(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1);
      step();
      chk("und_pc", {4'd0, pc}, TRAP ? 16'hFF0 : 16'h041);
      chk("und_depth", {12'd0, stack_depth}, 16'd0);
      chk_flags("und", 1'b0, 1'b1, 1'b0);
      drive(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
      chk("und2_pc", {4'd0, pc}, TRAP ? 16'hFF0 : 16'h042);
      chk("und2_depth", {12'd0, stack_depth}, 16'd0);

      // protocol error at depth 2
      drive(1'b1, 2'b10, 12'h050, 8'h00, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 2'b10, 12'h060, 8'h00, 1'b1, 1'b0, 1'b0);
      step(); chk("pe_pre_depth", {12'd0, stack_depth}, 16'd2);
      drive(1'b1, 2'b00, 12'h000, 8'h00, 1'b1, 1'b1, 1'b0);
      step();
      chk("pe_pc", {4'd0, pc}, 16'h061);
      chk("pe_depth", {12'd0, stack_depth}, 16'd2);
      chk_flags("pe", 1'b0, 1'b1, 1'b1);

      // async reset mid-call, checked before any further clock edge
      drive(1'b1, 2'b10, 12'h070, 8'h00, 1'b1, 1'b0, 1'b0);
      step(); chk("pre_rst_depth", {12'd0, stack_depth}, 16'd3);
      #2 reset = 1'b1;
      #1;
      chk("arst_pc", {4'd0, pc}, 16'h000);
      chk("arst_depth", {12'd0, stack_depth}, 16'd0);
      chk_flags("arst", 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'b00, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b0;
      step(); chk("post_rst_pc", {4'd0, pc}, 16'h001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and return-address-stack stage directly downstream of the instruction controller.
- Consumes the controller's enable_pc, select_address, push, pop and ret strobes, plus address fields of the current 19-bit instruction.
- Produces the registered 12-bit instruction-memory address for the next cycle.
- Owns the hardware call/return stack and its overflow/underflow status.

Parameters:
- PC_WIDTH, 12, width of program counter and jump address.
- OFFSET_WIDTH, 8, width of signed branch offset.
- STACK_DEPTH, 8, return-address-stack entries (power of 2, ≥2).
- RESET_VECTOR, 12'h000, PC value after reset.
- TRAP_VECTOR, 12'hFF0, PC loaded on stack fault (optional feature only).

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- enable_pc  input  1  advance/update PC this cycle.
- select_address  input  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 reserved.
- jump_address  input  PC_WIDTH  absolute target (instruction bits [11:0]).
- branch_offset  input  OFFSET_WIDTH  signed relative offset (instruction bits [7:0]).
- push  input  1  push return address (call).
- pop  input  1  discard top of stack.
- ret  input  1  next PC = top of stack (overrides select_address).
- pc  output  PC_WIDTH  current instruction address, registered.
- stack_depth  output  log2(STACK_DEPTH)+1  number of valid stack entries.
- stack_full  output  1  stack_depth == STACK_DEPTH.
- stack_empty  output  1  stack_depth == 0.
- stack_overflow  output  1  sticky: push attempted while full.
- stack_underflow  output  1  sticky: pop/ret attempted while empty.
- protocol_error  output  1  sticky: push and pop in the same enabled cycle.

Behaviour:
- Reset, asynchronous: pc=RESET_VECTOR, stack_depth=0, all sticky flags 0, stack contents don't-care. Reset mid-operation aborts any update; the first enabled edge after deassertion acts on pc=RESET_VECTOR.
- All outputs are registered; stack_full and stack_empty are decoded from the registered depth. One-cycle latency: inputs sampled at posedge, new pc visible after that edge.
- enable_pc=0: pc, stack and flags hold; push, pop and ret are ignored.
- Next-PC priority when enable_pc=1:
  1. ret
  2. select_address=10 → jump_address
  3. select_address=01 → pc+1+sext(branch_offset)
  4. otherwise → pc+1
- select_address=11 behaves as 00.
- Arithmetic is modulo 2^PC_WIDTH: 0xFFF+1 wraps to 0x000; negative offsets wrap below 0x000.
- push (not full): write pc+1 at entry[depth], depth+1. Push happens alongside the jump in the same cycle; the jump is taken regardless.
- push while full: write dropped, depth unchanged, stack_overflow set, jump still taken.
- ret (not empty): next pc = entry[depth-1].
- pop (not empty): depth-1.
- ret and pop together form a normal return: target read before the decrement, same edge.
- ret without pop: peek-return, depth unchanged.
- ret while empty: pc <= pc+1, stack_underflow set.
- pop while empty: depth stays 0, stack_underflow set.
- push and pop in the same enabled cycle: neither stack operation is performed, protocol_error set. PC follows the priority rules (ret still honoured if not empty).
- Sticky flags clear only on reset.

Optional Feature:
- Macro: PC_SEQ_STACK_TRAP_EN.
- Defined: any cycle that sets stack_overflow or stack_underflow, or would set it again while already set, loads pc=TRAP_VECTOR instead of the normal next PC. Stack is unchanged in that cycle.
- Undefined: faults only set flags; PC follows the rules above. TRAP_VECTOR is unused.

Test Plan:
- Sequential and wrap: reset, enable_pc=1, select=00 for 3 cycles → pc 0,1,2,3; with pc=0xFFF, one step → 0x000.
- Branch and jump: pc=0x010, select=01, offset=8'hFC → pc=0x00D; select=10, jump=0x3A5 → pc=0x3A5; enable_pc=0 → pc holds 0x3A5.
- Call/return: pc=0x020, select=10, jump=0x100, push=1 → pc=0x100, depth=1. Next ret+pop → pc=0x021, depth=0, no flags.
- Overflow: 8 push+jump cycles → stack_full=1. 9th push → stack_overflow=1, depth=8, pc=jump target. Trap build: pc=0xFF0.
- Underflow/protocol: empty stack, ret+pop at pc=0x040 → pc=0x041, stack_underflow=1. push+pop together at depth 2 → depth 2, protocol_error=1.
- Async reset mid-call: assert reset between edges after a push → pc=0x000, depth=0, flags 0 immediately, without waiting for a clock edge.
